// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-through, no-write-allocate cache with
// 4-word line refill, access timeout and saturating hit/miss counters.
module cache_controller #(
  parameter int WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int LINES = 32,
  parameter int TIMEOUT = 64,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int IW = $clog2(LINES),
  localparam int TW = AW - IW - 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      cpu_address,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [WIDTH-1:0]   cpu_write_data,
  output logic [WIDTH-1:0]   cpu_read_data,
  output logic               cpu_stall,
  output logic [AW-1:0]      mem_address,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic [WIDTH-1:0]   mem_write_data,
  input  logic               mem_ready,
  input  logic [4*WIDTH-1:0] mem_read_data,
  output logic               mem_error,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
);
  typedef enum logic [1:0] {IDLE, WRITE_MEM, REFILL, RESPOND} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, mem_address_q, mem_address_d;
  logic [WIDTH-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic rd_en_q, rd_en_d, wr_en_q, wr_en_d, err_q, err_d;
  logic [6:0] cnt_q, cnt_d;
  logic [15:0] hits_q, hits_d, miss_q, miss_d;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0] tag_q [LINES];
  logic [WIDTH-1:0] data_q [LINES][4];
  logic [1:0] off, r_off;
  logic [IW-1:0] idx, r_idx;
  logic [TW-1:0] tg, r_tg;
  logic hit, rd_hit, rd_miss, wr, acc, done, tmo, refill_done;
  assign off = cpu_address[1:0];
  assign idx = cpu_address[IW+1:2];
  assign tg = cpu_address[AW-1:IW+2];
  assign r_off = addr_q[1:0];
  assign r_idx = addr_q[IW+1:2];
  assign r_tg = addr_q[AW-1:IW+2];
  assign hit = valid_q[idx] && tag_q[idx] == tg;
  always_comb begin
    rd_hit = state_q == IDLE && cpu_read && !cpu_write && hit;
    rd_miss = state_q == IDLE && cpu_read && !cpu_write && !hit;
    wr = state_q == IDLE && cpu_write;
    acc = state_q == WRITE_MEM || state_q == REFILL;
    // the first access cycle ignores mem_ready (cnt_q is still 0 there)
    done = acc && cnt_q != 7'd0 && mem_ready;
    tmo = acc && !done && cnt_q == 7'(TIMEOUT - 1);
    refill_done = state_q == REFILL && done;
    cpu_stall = wr || rd_miss || acc;
    state_d = wr ? WRITE_MEM : rd_miss ? REFILL : (done || tmo) ? RESPOND :
              state_q == RESPOND ? IDLE : state_q;
    addr_d = (wr || rd_miss) ? cpu_address : addr_q;
    mem_address_d = wr ? cpu_address : rd_miss ? {cpu_address[AW-1:2], 2'b00} : mem_address_q;
    wdata_d = wr ? cpu_write_data : wdata_q;
    rd_en_d = rd_miss || (rd_en_q && !(done || tmo));
    wr_en_d = wr || (wr_en_q && !(done || tmo));
    cnt_d = (wr || rd_miss) ? 7'd0 : acc ? cnt_q + 7'd1 : cnt_q;
    err_d = err_q || tmo;
    hits_d = (rd_hit && hits_q != 16'hFFFF) ? hits_q + 16'd1 : hits_q;
    miss_d = (rd_miss && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
    rdata_d = rd_hit ? data_q[idx][off] :
              refill_done ? mem_read_data[WIDTH*r_off +: WIDTH] : rdata_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      mem_address_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      hits_q <= '0;
      miss_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      mem_address_q <= mem_address_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      hits_q <= hits_d;
      miss_q <= miss_d;
      if (refill_done) valid_q[r_idx] <= 1'b1;
    end
  end
  // tag/data arrays are qualified by valid_q, so they need no reset
  always_ff @(posedge clk) begin
    if (wr && hit) data_q[idx][off] <= cpu_write_data;
    if (refill_done) begin
      tag_q[r_idx] <= r_tg;
      for (int i = 0; i < 4; i++) data_q[r_idx][i] <= mem_read_data[WIDTH*i +: WIDTH];
    end
  end
  assign cpu_read_data = rdata_q;
  assign mem_address = mem_address_q;
  assign mem_read_en = rd_en_q;
  assign mem_write_en = wr_en_q;
  assign mem_write_data = wdata_q;
  assign mem_error = err_q;
  assign hit_count = hits_q;
  assign miss_count = miss_q;
endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through, no-write-allocate cache controller sitting between the CPU load/store port and the word-addressed main memory. It holds the tag/valid/data arrays, serves read hits locally, and refills 4-word blocks from memory on read misses. Every store is forwarded to memory, and the cached copy is updated on a hit. A timeout counter and hit/miss statistics counters are included.

## Interface
- WIDTH, 32, data word width
- MEM_DEPTH, 1024, memory size in words; AW = $clog2(MEM_DEPTH) = 10
- LINES, 32, cache lines of 4 words; IW = $clog2(LINES) = 5; tag width TW = AW-IW-2 = 3
- TIMEOUT, 64, maximum cycles spent in one memory access
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_address  in  AW  word address; [1:0] offset, [IW+1:2] index, [AW-1:IW+2] tag
- cpu_read  in  1  load request
- cpu_write  in  1  store request; wins if asserted together with cpu_read
- cpu_write_data  in  WIDTH  store data
- cpu_read_data  out  WIDTH  load result, registered
- cpu_stall  out  1  combinational; a request completes in a cycle where it is asserted and cpu_stall=0
- mem_address  out  AW  memory word address, registered
- mem_read_en  out  1  block read request
- mem_write_en  out  1  word write request
- mem_write_data  out  WIDTH  store data to memory
- mem_ready  in  1  memory access complete
- mem_read_data  in  4*WIDTH  refill block; word i is at bits [WIDTH*i +: WIDTH]
- mem_error  out  1  sticky; set when an access times out
- hit_count  out  16  read hits, saturating at 16'hFFFF
- miss_count  out  16  read misses, saturating at 16'hFFFF

## Operation
- States: IDLE, WRITE_MEM, REFILL, RESPOND.
- IDLE, no request: cpu_stall=0, no state change.
- IDLE, read hit (valid[index] and tag match):
  - cpu_stall=0.
  - cpu_read_data loads data[index][offset] at the edge.
  - hit_count increments.
  - Stay in IDLE.
- IDLE, read miss:
  - cpu_stall=1; miss_count increments.
  - Latch address; go to REFILL with mem_address={tag,index,2'b00} and mem_read_en=1.
- IDLE, write:
  - cpu_stall=1.
  - Latch address and data; go to WRITE_MEM with mem_address=cpu_address, mem_write_data=cpu_write_data, mem_write_en=1.
  - On a hit, data[index][offset] is updated at the same edge.
  - A write miss leaves the cache unchanged.
- WRITE_MEM / REFILL:
  - cpu_stall=1; the request enable is held constant.
  - mem_ready is ignored in the first cycle of the access and sampled from the second cycle on.
- REFILL completion (mem_ready sampled 1):
  - Write all 4 words of mem_read_data into data[index].
  - Set tag[index] and valid[index].
  - cpu_read_data loads word[offset] of the block.
  - Go to RESPOND.
- WRITE_MEM completion: go to RESPOND.
- RESPOND:
  - One cycle; cpu_stall=0 and both memory enables are 0.
  - This is the completion cycle of the pending request.
  - Counters do not change; the next state is IDLE.
  - A new request is accepted only from the following cycle.
- Timeout:
  - A 7-bit counter clears on entry to WRITE_MEM/REFILL and increments each cycle.
  - If it reaches TIMEOUT-1 without mem_ready, set mem_error and go to RESPOND.
  - On a refill timeout, the line stays invalid and cpu_read_data is unchanged.
- mem_read_en and mem_write_en are never high together. cpu_read_data holds its value until the next read completion.
- Requester contract: cpu_address, cpu_write_data and the request lines are held stable while cpu_stall=1.
- Memory contract: mem_ready stays low from the second cycle of an access until that access is complete.

## Timing
- Reset values: all valid bits 0, state IDLE, cpu_read_data=0, mem_address=0, mem_read_en=0, mem_write_en=0, mem_write_data=0, mem_error=0, hit_count=0, miss_count=0, timeout counter=0.
- cpu_stall: its value follows from state and inputs, so it is 0 in IDLE with no request.
- Reset mid-access aborts the access: enables drop asynchronously, and a partially refilled line stays invalid.
- Read hit: 1 cycle; data is valid the cycle after completion.
- Read miss with memory latency L (mem_ready first high L cycles after the enable rises, L≥1):
  - REFILL lasts L+1 cycles, with completion at the following RESPOND.
  - Total latency is L+3 cycles from request to completion.
- Write with memory latency L: L+3 cycles, regardless of hit or miss.
- Counters saturate and never wrap.

## Test plan
- Reset, then read address 0x004 with a memory block {0x44,0x33,0x22,0x11} at 0x004..0x007:
  - Memory latency 4; expect mem_read_en=1 with mem_address=0x004.
  - Completion after 7 cycles; cpu_read_data=0x11.
  - miss_count=1, hit_count=0.
- Then read 0x006: no memory access, stall low, cpu_read_data=0x33 next cycle, hit_count=1.
- Write 0x005←0xABCD (a hit):
  - mem_write_en=1, mem_write_data=0xABCD, latency 1, so 4 cycles total.
  - A following read of 0x005 hits and returns 0xABCD.
- Write 0x3F0←0x1 (a miss): memory is written; the following read of 0x3F0 is counted as a miss and refilled.
- Conflict: read 0x084 (same index as 0x004, different tag) misses and replaces the line. A read of 0x004 afterwards misses again.
- Hold mem_ready low during a refill:
  - After 64 cycles, mem_error=1 and cpu_stall drops for one cycle.
  - The line stays invalid; assert reset mid-refill and check that all outputs return to their reset values.
